sprite_anim_seq: RTL and testbench

//  Generates the 4-bit spriteState that indexes the 64x64 sprite-sheet tile mux.

---
 rtl/sprite_anim_seq.sv | 104 ++++++++++
 tb/tb_sprite_anim_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: turns IR commands into a 4-bit sprite tile index that steps on frame_tick.
// Define ANIM_PINGPONG_EN to make IDLE bounce 0..3..0 instead of wrapping 3->0.
module sprite_anim_seq #(
  parameter int STEP_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       ir_valid,
  input  logic [1:0] ir_cmd,
  output logic       ir_ready,
  output logic [3:0] spriteState,
  output logic       jump_done
);
  typedef enum logic [1:0] {IDLE, WALK, JUMP} mode_t;
  mode_t      mode_q, mode_d, req;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] state_q, state_d;
  logic       pend_q, pend_d, ready_q, ready_d, done_q, done_d, chg;
`ifdef ANIM_PINGPONG_EN
  logic       dir_q, dir_d, up;
`endif
  function automatic logic [3:0] first(input mode_t m);
    return (m == WALK) ? 4'd4 : (m == JUMP) ? 4'd12 : 4'd0;
  endfunction
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    state_d = state_q;
    done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_d   = dir_q;
    up      = dir_q ? (state_q != 4'd3) : (state_q == 4'd0);
`endif
    req = (ir_cmd == 2'b00) ? IDLE : (ir_cmd == 2'b01) ? WALK : (ir_cmd == 2'b10) ? JUMP : mode_q;
    chg = ir_valid && ready_q && (req != mode_q);
    // A mode change beats a coincident tick: the new sequence loads on that tick.
    if (chg) begin
      mode_d  = req;
      cnt_d   = 8'd0;
      pend_d  = !frame_tick;
      state_d = frame_tick ? first(req) : state_q;
`ifdef ANIM_PINGPONG_EN
      dir_d   = 1'b1;
`endif
    end else if (frame_tick) begin
      if (pend_q) begin
        state_d = first(mode_q);
        pend_d  = 1'b0;
        cnt_d   = 8'd0;
      end else if (cnt_q == 8'(STEP_FRAMES - 1)) begin
        cnt_d = 8'd0;
        if (mode_q == WALK) begin
          state_d = (state_q == 4'd11) ? 4'd4 : state_q + 4'd1;
        end else if (mode_q == JUMP) begin
          mode_d  = (state_q == 4'd15) ? IDLE : JUMP;
          done_d  = (state_q == 4'd15);
          state_d = (state_q == 4'd15) ? 4'd0 : state_q + 4'd1;
`ifdef ANIM_PINGPONG_EN
          dir_d   = 1'b1;
`endif
        end else begin
`ifdef ANIM_PINGPONG_EN
          dir_d   = up;
          state_d = up ? state_q + 4'd1 : state_q - 4'd1;
`else
          state_d = (state_q == 4'd3) ? 4'd0 : state_q + 4'd1;
`endif
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    // Ready stays low through the jump_done cycle and returns one cycle later.
    ready_d = (mode_d != JUMP) && !done_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= IDLE;
      cnt_q   <= 8'd0;
      state_q <= 4'd0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_q   <= 1'b1;
`endif
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef ANIM_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end
  assign ir_ready    = ready_q;
  assign spriteState = state_q;
  assign jump_done   = done_q;
endmodule

// File: tb/tb_sprite_anim_seq.sv
// tb_sprite_anim_seq: two instances (STEP_FRAMES=2 and 1) checked every cycle against a
// sequence-table model, plus hand-computed expectations for reset, idle, walk, jump and collisions.
module tb_sprite_anim_seq;
  logic clk = 0, reset_n = 0, frame_tick = 0, ir_valid = 0;
  logic [1:0] ir_cmd = 0;
  logic [3:0] s2, s1;
  logic r2, r1, j2, j1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  sprite_anim_seq #(.STEP_FRAMES(2)) dut2 (.clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .ir_valid(ir_valid), .ir_cmd(ir_cmd), .ir_ready(r2), .spriteState(s2), .jump_done(j2));
  sprite_anim_seq #(.STEP_FRAMES(1)) dut1 (.clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .ir_valid(ir_valid), .ir_cmd(ir_cmd), .ir_ready(r1), .spriteState(s1), .jump_done(j1));

`ifdef ANIM_PINGPONG_EN
  localparam int ILEN = 6;
  int idle_seq [6] = '{0, 1, 2, 3, 2, 1};
  int t2_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2};
`else
  localparam int ILEN = 4;
  int idle_seq [4] = '{0, 1, 2, 3};
  int t2_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
`endif

  // Model: mode 0 idle / 1 walk / 2 jump, position within the mode's frame table.
  int steps [2] = '{2, 1};
  int m_mode [2] = '{0, 0};
  int m_pos [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_s [2] = '{0, 0};
  bit m_pend [2] = '{0, 0};
  bit m_jd [2] = '{0, 0};
  bit m_rdy [2] = '{1, 1};
  int nm;

  function automatic int first_of(input int m);
    return m == 1 ? 4 : m == 2 ? 12 : 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_s[k] = 0;
        m_pend[k] = 0; m_jd[k] = 0; m_rdy[k] = 1;
      end else begin
        m_jd[k] = 0;
        nm = (ir_cmd == 2'b11) ? m_mode[k] : int'(ir_cmd);
        if (ir_valid && m_rdy[k] && nm != m_mode[k]) begin
          m_mode[k] = nm; m_pos[k] = 0; m_cnt[k] = 0;
          if (frame_tick) m_s[k] = first_of(nm);
          m_pend[k] = !frame_tick;
        end else if (frame_tick) begin
          if (m_pend[k]) begin
            m_s[k] = first_of(m_mode[k]); m_pend[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
          end else if (m_cnt[k] == steps[k] - 1) begin
            m_cnt[k] = 0;
            m_pos[k] = m_pos[k] + 1;
            if (m_mode[k] == 0) begin
              m_pos[k] = m_pos[k] % ILEN;
              m_s[k] = idle_seq[m_pos[k]];
            end else if (m_mode[k] == 1) begin
              m_pos[k] = m_pos[k] % 8;
              m_s[k] = 4 + m_pos[k];
            end else if (m_pos[k] == 4) begin
              m_mode[k] = 0; m_pos[k] = 0; m_s[k] = 0; m_jd[k] = 1;
            end else begin
              m_s[k] = 12 + m_pos[k];
            end
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
        m_rdy[k] = m_mode[k] != 2 && !m_jd[k];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_s2", int'(s2), m_s[0]);
    chk("model_r2", int'(r2), int'(m_rdy[0]));
    chk("model_j2", int'(j2), int'(m_jd[0]));
    chk("model_s1", int'(s1), m_s[1]);
    chk("model_r1", int'(r1), int'(m_rdy[1]));
    chk("model_j1", int'(j1), int'(m_jd[1]));
  end

  task automatic cyc(input logic t, input logic v, input logic [1:0] c);
    @(negedge clk);
    frame_tick = t; ir_valid = v; ir_cmd = c;
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    cyc(1, 0, 2'b00);
    cyc(0, 0, 2'b00);
  endtask

  initial begin
    cyc(0, 0, 2'b00);
    cyc(0, 0, 2'b00);
    @(negedge clk) reset_n = 1;
    // T1: async reset in the middle of WALK
    cyc(0, 1, 2'b01);
    tick(); tick(); tick();
    chk("t1_pre_s1", int'(s1), 6);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t1_s1", int'(s1), 0); chk("t1_r1", int'(r1), 1); chk("t1_j1", int'(j1), 0);
    chk("t1_s2", int'(s2), 0); chk("t1_r2", int'(r2), 1);
    @(negedge clk) reset_n = 1;
    // T2: idle loop, value before each tick at STEP_FRAMES=2
    for (int i = 0; i < 10; i++) begin
      chk("t2_idle", int'(s2), t2_exp[i]);
      tick();
    end
    chk("t2_end_s1", int'(s1), 2);
    chk("t2_end_s2", int'(s2), 1);
    // T3: walk at STEP_FRAMES=1, then re-issued WALK must not restart
    cyc(0, 1, 2'b01);
    chk("t3_pend_s1", int'(s1), 2);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t3_walk", int'(s1), 4 + (i % 8));
    end
    tick(); tick(); tick();
    chk("t3_at7", int'(s1), 7);
    cyc(0, 1, 2'b01);
    tick();
    chk("t3_norestart", int'(s1), 8);
    // T4: jump one-shot, STOP refused while jumping
    cyc(0, 1, 2'b10);
    chk("t4_rdy0", int'(r1), 0);
    chk("t4_hold", int'(s1), 8);
    tick(); chk("t4_12", int'(s1), 12);
    tick(); chk("t4_13", int'(s1), 13);
    cyc(0, 1, 2'b00);
    cyc(0, 0, 2'b00);
    tick(); chk("t4_14", int'(s1), 14);
    tick(); chk("t4_15", int'(s1), 15);
    cyc(1, 0, 2'b00);
    chk("t4_end_s", int'(s1), 0); chk("t4_end_jd", int'(j1), 1); chk("t4_end_rdy", int'(r1), 0);
    cyc(0, 0, 2'b00);
    chk("t4_after_jd", int'(j1), 0); chk("t4_after_rdy", int'(r1), 1);
    for (int i = 0; i < 6; i++) tick();
    // T5: collision of WALK with frame_tick at idle state 2, then reserved command
    @(negedge clk) reset_n = 0;
    @(negedge clk) reset_n = 1;
    tick(); tick();
    chk("t5_at2", int'(s1), 2);
    cyc(1, 1, 2'b01);
    chk("t5_collide", int'(s1), 4);
    cyc(0, 1, 2'b11);
    chk("t5_rsv_rdy", int'(r1), 1);
    chk("t5_rsv_s", int'(s1), 4);
    cyc(0, 0, 2'b00);
    tick();
    chk("t5_rsv_walk", int'(s1), 5);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
